// File: rtl/branch_pkg.sv
// Shared constants and FSM encoding for the PC sequencer slice.
// Holds the state enum, reset PC default, word width and PC increment.
package branch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STAT_W = 16;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    localparam logic [1:0] S_INIT     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    typedef enum logic [1:0] {
        INIT     = S_INIT,
        FETCH    = S_FETCH,
        REDIRECT = S_REDIRECT
    } state_e;

endpackage

// File: rtl/branch_stats_counter.sv
// Saturating branch / taken-branch event counters.
// Ports: clk, rst (sync, active-high), inc_branch, inc_taken in;
//        branch_count, taken_count [15:0] out, stick at 16'hFFFF.
module branch_stats_counter
    import branch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_branch,
    input  logic              inc_taken,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] taken_count
);

    localparam logic [STAT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            if (inc_branch && branch_count != CNT_MAX)
                branch_count <= branch_count + 1'b1;
            if (inc_taken && taken_count != CNT_MAX)
                taken_count <= taken_count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC select with fetch handshake.
// Ports: clk, rst (sync, active-high), fetch_ready, stall,
//        branch_valid, branch_ne, zero, branch_target in;
//        pc, pc_plus4, fetch_valid, flush, taken, align_err out.
// PC_SEQUENCER_BRANCH_STATS_EN adds branch_count / taken_count.
module pc_sequencer
    import branch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ready,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic              branch_ne,
    input  logic              zero,
    input  logic [XLEN-1:0]   branch_target,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              fetch_valid,
    output logic              flush,
    output logic              taken,
    output logic              align_err
`ifdef PC_SEQUENCER_BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] taken_count
`endif
);

    state_e state;

    logic [XLEN-1:0] tgt_aligned;

    assign pc_plus4    = pc + PC_INC;
    assign taken       = branch_valid & (zero ^ branch_ne);
    assign tgt_aligned = {branch_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            flush     <= 1'b0;
            align_err <= 1'b0;
            unique case (state)
                INIT: begin
                    state       <= FETCH;
                    fetch_valid <= 1'b1;
                end
                FETCH: begin
                    // A taken branch overrides stall and handshake.
                    if (taken) begin
                        state       <= REDIRECT;
                        pc          <= tgt_aligned;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b1;
                        align_err   <= |branch_target[1:0];
                    end else if (!stall && fetch_ready) begin
                        pc <= pc_plus4;
                    end
                end
                REDIRECT: begin
                    // Branches seen here belong to the flushed slot.
                    state       <= FETCH;
                    fetch_valid <= 1'b1;
                end
                default: begin
                    state       <= INIT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQUENCER_BRANCH_STATS_EN
    logic in_fetch;

    assign in_fetch = (state == FETCH);

    branch_stats_counter u_stats (
        .clk          (clk),
        .rst          (rst),
        .inc_branch   (in_fetch & branch_valid),
        .inc_taken    (in_fetch & taken),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table + scoreboard queue.
// Stats saturation sequence runs only with PC_SEQUENCER_BRANCH_STATS_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        stall;
    logic        branch_valid;
    logic        branch_ne;
    logic        zero;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        taken;
    logic        align_err;
`ifdef PC_SEQUENCER_BRANCH_STATS_EN
    logic [15:0] branch_count;
    logic [15:0] taken_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_ready   (fetch_ready),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .taken         (taken),
        .align_err     (align_err)
`ifdef PC_SEQUENCER_BRANCH_STATS_EN
        ,
        .branch_count  (branch_count),
        .taken_count   (taken_count)
`endif
    );

    typedef struct {
        bit          rst;
        bit          fr;
        bit          st;
        bit          bv;
        bit          bne;
        bit          z;
        logic [31:0] tgt;
        logic        tk;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ae;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ae;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(bit r, bit fr, bit st, bit bv, bit bne,
                               bit z, logic [31:0] tgt, logic tk,
                               logic [31:0] epc, logic fv, logic fl,
                               logic ae);
        vec_t x;
        x.rst = r;  x.fr = fr; x.st = st; x.bv = bv;
        x.bne = bne; x.z = z; x.tgt = tgt; x.tk = tk;
        x.pc = epc; x.fv = fv; x.fl = fl; x.ae = ae;
        return x;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(bit r, bit fr, bit st, bit bv, bit bne, bit z,
                         logic [31:0] tgt);
        rst = r; fetch_ready = fr; stall = st;
        branch_valid = bv; branch_ne = bne; zero = z;
        branch_target = tgt;
    endtask

    initial begin
        exp_t e;
        drive(1, 0, 0, 0, 0, 0, 32'h0);

        //        rst fr st bv bn z  target         tk pc            fv fl ae
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0000, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0004, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_000C, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0010, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0010, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0010, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0014, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h0,        0, 32'h0000_0014, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 32'h40,       1, 32'h0000_0040, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 1, 32'h200,      1, 32'h0000_0040, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0044, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 1, 32'h80,       0, 32'h0000_0048, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 32'h203,      1, 32'h0000_0200, 0, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0200, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 0, 1, 32'h102,      1, 32'h0000_0100, 0, 1, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0000, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'h0000_0004, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].fr, tbl[i].st, tbl[i].bv,
                  tbl[i].bne, tbl[i].z, tbl[i].tgt);
            e.idx = i; e.pc = tbl[i].pc; e.fv = tbl[i].fv;
            e.fl = tbl[i].fl; e.ae = tbl[i].ae;
            sb.push_back(e);
            #1;
            chk("taken", i, {31'b0, taken}, {31'b0, tbl[i].tk});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", i, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("pc", e.idx, pc, e.pc);
                chk("pc_plus4", e.idx, pc_plus4, e.pc + 32'd4);
                chk("fetch_valid", e.idx, {31'b0, fetch_valid},
                    {31'b0, e.fv});
                chk("flush", e.idx, {31'b0, flush}, {31'b0, e.fl});
                chk("align_err", e.idx, {31'b0, align_err},
                    {31'b0, e.ae});
            end
        end

`ifdef PC_SEQUENCER_BRANCH_STATS_EN
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk("branch_count_rst", 0, {16'b0, branch_count}, 32'd0);
        chk("taken_count_rst", 0, {16'b0, taken_count}, 32'd0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            drive(0, 1, 0, 1, 0, 1, 32'h40);
            @(posedge clk);
            @(negedge clk);
            drive(0, 1, 0, 0, 0, 0, 32'h0);
            @(posedge clk);
        end
        #1;
        chk("branch_count_sat", 0, {16'b0, branch_count}, 32'h0000_FFFF);
        chk("taken_count_sat", 0, {16'b0, taken_count}, 32'h0000_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
